// File: rtl/freq_divider_multi.sv
// freq_divider_multi: NCH independent runtime-programmable clock dividers.
// Each channel counts 0..div_act-1 and emits a registered divided clock (low
// phase first, then high_act cycles high) plus a one-cycle tick after each
// wrap. New period/high-time pairs arrive over a valid/ready port, are held in
// a per-channel shadow, and are applied only at the wrap cycle. The old period
// therefore always completes and the divided clock never shows a runt pulse.
module freq_divider_multi #(
  parameter int NCH      = 4,
  parameter int DIVW     = 20,
  parameter int DIV_RST  = 50000,
  parameter int HIGH_RST = 25000,
  parameter int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NCH-1:0]  EN,
  input  logic            LD_VALID,
  output logic            LD_READY,
  input  logic [CHW-1:0]  LD_CH,
  input  logic [DIVW-1:0] LD_DIV,
  input  logic [DIVW-1:0] LD_HIGH,
  output logic            LD_ERR,
  output logic [NCH-1:0]  CLK_Out,
  output logic [NCH-1:0]  TICK
);

  // Channel count at the width of a zero-extended channel select.
  localparam logic [CHW:0]    NCH_W     = (CHW+1)'(NCH);
  localparam logic [DIVW-1:0] DIV_DEF   = DIVW'(DIV_RST);
  localparam logic [DIVW-1:0] HIGH_DEF  = DIVW'(HIGH_RST);
  localparam logic [DIVW-1:0] DIV_MIN   = DIVW'(2);

  logic [DIVW-1:0] cnt       [NCH];
  logic [DIVW-1:0] div_act   [NCH];
  logic [DIVW-1:0] high_act  [NCH];
  logic [DIVW-1:0] div_pend  [NCH];
  logic [DIVW-1:0] high_pend [NCH];
  logic [NCH-1:0]  pend;

  logic [NCH-1:0]  wrap;
  logic [NCH-1:0]  apply;
  logic [NCH-1:0]  hit;
  logic [NCH-1:0]  ld_sel;
  logic [NCH-1:0]  accept;
  logic            ch_ok;
  logic            load_bad;
  logic            xfer;

  // Decode the load port: channel select, readiness and validity of the request.
  always_comb begin
    ch_ok = ({1'b0, LD_CH} < NCH_W);
    ld_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      ld_sel[i] = (LD_CH == CHW'(i));
    end
    // An out-of-range channel is always ready so the request can be rejected.
    LD_READY = !ch_ok || !(|(ld_sel & pend));
    xfer     = LD_VALID && LD_READY;
    load_bad = !ch_ok || (LD_DIV < DIV_MIN) || (LD_HIGH == '0) || (LD_HIGH >= LD_DIV);
    accept   = (xfer && !load_bad) ? ld_sel : '0;
  end

  // Per-channel wrap, shadow-apply and high-phase decode from the current count.
  always_comb begin
    wrap  = '0;
    apply = '0;
    hit   = '0;
    for (int i = 0; i < NCH; i++) begin
      wrap[i]  = EN[i] && (cnt[i] == (div_act[i] - DIVW'(1)));
      // A disabled channel has no period in flight, so it applies at once.
      apply[i] = pend[i] && (wrap[i] || !EN[i]);
      // Validation guarantees high_act < div_act, so this cannot underflow.
      hit[i]   = (cnt[i] >= (div_act[i] - high_act[i]));
    end
  end

  // Period counters: held at zero while disabled, wrap at div_act-1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!EN[i] || wrap[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DIVW'(1);
        end
      end
    end
  end

  // Shadow and active divisor registers with the pending flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend <= '0;
      for (int i = 0; i < NCH; i++) begin
        div_act[i]   <= DIV_DEF;
        high_act[i]  <= HIGH_DEF;
        div_pend[i]  <= DIV_DEF;
        high_pend[i] <= HIGH_DEF;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        // accept needs !pend and apply needs pend, so they never coincide.
        if (accept[i]) begin
          div_pend[i]  <= LD_DIV;
          high_pend[i] <= LD_HIGH;
          pend[i]      <= 1'b1;
        end else if (apply[i]) begin
          div_act[i]  <= div_pend[i];
          high_act[i] <= high_pend[i];
          pend[i]     <= 1'b0;
        end
      end
    end
  end

  // Registered divided clocks and period ticks.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CLK_Out <= '0;
      TICK    <= '0;
    end else begin
      CLK_Out <= EN & hit;
      TICK    <= wrap;
    end
  end

  // One-cycle error pulse for a transferred but rejected load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LD_ERR <= 1'b0;
    end else begin
      LD_ERR <= xfer && load_bad;
    end
  end

endmodule

// File: tb/tb_freq_divider_multi.sv
// Directed bench for freq_divider_multi with NCH=2, DIVW=8, DIV_RST=10,
// HIGH_RST=4. The channel select is widened to 2 bits so an out-of-range
// channel can be driven. Expected waveforms are hand-derived bit vectors
// where bit k holds the value sampled after the (k+1)-th edge of a capture.
module tb_freq_divider_multi;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] EN;
  logic       LD_VALID;
  logic       LD_READY;
  logic [1:0] LD_CH;
  logic [7:0] LD_DIV;
  logic [7:0] LD_HIGH;
  logic       LD_ERR;
  logic [1:0] CLK_Out;
  logic [1:0] TICK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] c0, c1, t0, t1, rdy, er;

  freq_divider_multi #(
    .NCH(2), .DIVW(8), .DIV_RST(10), .HIGH_RST(4), .CHW(2)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_CH(LD_CH),
    .LD_DIV(LD_DIV), .LD_HIGH(LD_HIGH), .LD_ERR(LD_ERR),
    .CLK_Out(CLK_Out), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic capture(input int n);
    c0 = '0; c1 = '0; t0 = '0; t1 = '0; rdy = '0; er = '0;
    for (int i = 0; i < n; i++) begin
      step();
      c0[i]  = CLK_Out[0];
      c1[i]  = CLK_Out[1];
      t0[i]  = TICK[0];
      t1[i]  = TICK[1];
      rdy[i] = LD_READY;
      er[i]  = LD_ERR;
    end
  endtask

  task automatic inv_load(input string tag, input logic [1:0] ch, input logic [7:0] dv,
                          input logic [7:0] hi);
    LD_CH = ch; LD_DIV = dv; LD_HIGH = hi; LD_VALID = 1'b1;
    #1;
    check({tag, "_rdy_pre"}, 32'(LD_READY), 32'd1);
    step();
    LD_VALID = 1'b0;
    check({tag, "_err_on"}, 32'(LD_ERR), 32'd1);
    step();
    check({tag, "_err_off"}, 32'(LD_ERR), 32'd0);
    check({tag, "_rdy_post"}, 32'(LD_READY), 32'd1);
  endtask

  initial begin
    RST = 1'b1; EN = 2'b00; LD_VALID = 1'b0; LD_CH = 2'd0; LD_DIV = 8'd0; LD_HIGH = 8'd0;
    repeat (3) step();
    check("rst_clk",   32'(CLK_Out),  32'd0);
    check("rst_tick",  32'(TICK),     32'd0);
    check("rst_err",   32'(LD_ERR),   32'd0);
    check("rst_ready", 32'(LD_READY), 32'd1);

    // Default period 10, high 4 on both channels.
    RST = 1'b0; EN = 2'b11;
    capture(20);
    check("p10_clk0",  c0,  32'h000F03C0);
    check("p10_clk1",  c1,  32'h000F03C0);
    check("p10_tick0", t0,  32'h00080200);
    check("p10_tick1", t1,  32'h00080200);
    check("p10_rdy",   rdy, 32'h000FFFFF);
    check("p10_err",   er,  32'h00000000);

    // Load ch1 DIV=4 HIGH=1 while its count is 3.
    repeat (3) step();
    LD_VALID = 1'b1; LD_CH = 2'd1; LD_DIV = 8'd4; LD_HIGH = 8'd1;
    #1;
    check("ld1_rdy_pre", 32'(LD_READY), 32'd1);
    step();
    LD_VALID = 1'b0;
    check("ld1_rdy_busy", 32'(LD_READY), 32'd0);
    check("ld1_err",      32'(LD_ERR),   32'd0);
    capture(14);
    check("ld1_clk1",  c1,  32'h0000223C);
    check("ld1_tick1", t1,  32'h00002220);
    check("ld1_rdy",   rdy, 32'h00003FE0);
    check("ld1_clk0",  c0,  32'h0000303C);
    check("ld1_tick0", t0,  32'h00000020);

    // Rejected loads.
    inv_load("inv_div1",  2'd0, 8'd1, 8'd0);
    inv_load("inv_hi_eq", 2'd0, 8'd5, 8'd5);
    inv_load("inv_ch3",   2'd3, 8'd4, 8'd2);

    // Load ch0 DIV=6 HIGH=3 exactly in its wrap cycle.
    LD_CH = 2'd0;
    repeat (5) step();
    LD_VALID = 1'b1; LD_DIV = 8'd6; LD_HIGH = 8'd3;
    #1;
    check("wrp_rdy_pre", 32'(LD_READY), 32'd1);
    step();
    LD_VALID = 1'b0;
    check("wrp_tick0", 32'(TICK[0]),    32'd1);
    check("wrp_clk0",  32'(CLK_Out[0]), 32'd1);
    check("wrp_rdy",   32'(LD_READY),   32'd0);
    capture(22);
    check("wrp_clk0_seq",  c0,  32'h0038E3C0);
    check("wrp_tick0_seq", t0,  32'h00208200);
    check("wrp_rdy_seq",   rdy, 32'h003FFE00);
    check("wrp_err_seq",   er,  32'h00000000);

    // Disabled ch0: load DIV=8 HIGH=2 applies on the following edge.
    EN = 2'b10;
    LD_VALID = 1'b1; LD_CH = 2'd0; LD_DIV = 8'd8; LD_HIGH = 8'd2;
    #1;
    check("dis_rdy_pre", 32'(LD_READY), 32'd1);
    step();
    LD_VALID = 1'b0;
    check("dis_clk0",  32'(CLK_Out[0]), 32'd0);
    check("dis_tick0", 32'(TICK[0]),    32'd0);
    check("dis_rdy",   32'(LD_READY),   32'd0);
    step();
    check("dis_apply_rdy",  32'(LD_READY),   32'd1);
    check("dis_apply_clk0", 32'(CLK_Out[0]), 32'd0);
    EN = 2'b11;
    capture(16);
    check("en_clk0",  c0, 32'h0000C0C0);
    check("en_tick0", t0, 32'h00008080);

    // Reset mid-period with ch1 pending.
    repeat (6) step();
    LD_VALID = 1'b1; LD_CH = 2'd1; LD_DIV = 8'd6; LD_HIGH = 8'd2;
    #1;
    check("mr_rdy_pre", 32'(LD_READY), 32'd1);
    step();
    LD_VALID = 1'b0;
    check("mr_pend",      32'(LD_READY),   32'd0);
    check("mr_clk0_high", 32'(CLK_Out[0]), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("mr_async_clk",  32'(CLK_Out),  32'd0);
    check("mr_async_tick", 32'(TICK),     32'd0);
    check("mr_async_err",  32'(LD_ERR),   32'd0);
    check("mr_async_rdy",  32'(LD_READY), 32'd1);
    step();
    step();
    RST = 1'b0;
    capture(10);
    check("mr_clk0",  c0,  32'h000003C0);
    check("mr_clk1",  c1,  32'h000003C0);
    check("mr_tick0", t0,  32'h00000200);
    check("mr_tick1", t1,  32'h00000200);
    check("mr_rdy",   rdy, 32'h000003FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
